// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, word size and
// the request legality check applied at acceptance.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    localparam int unsigned WORD_BYTES = 4;

    // Flags a word access that is misaligned or lies at/after the byte limit.
    function automatic logic lsu_addr_err(input logic [63:0] addr,
                                          input logic [63:0] limit);
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Data-cache initiator: accepts one core load/store, holds the cache strobes
// for ACCESS_LAT cycles, then returns data or an ack over a response handshake.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_WORDS  = 64,
    parameter int unsigned ACCESS_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wdata,
    output logic              cache_write,
    output logic              cache_read,
    input  logic [DATA_W-1:0] cache_rdata
);

    localparam int unsigned      CNT_W      = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(ACCESS_LAT - 1);
    localparam logic [63:0]      ADDR_LIMIT = 64'(MEM_WORDS) * 64'(WORD_BYTES);

    lsu_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

    logic              r_req_ready,   w_req_ready_nxt;
    logic              r_resp_valid,  w_resp_valid_nxt;
    logic [DATA_W-1:0] r_resp_rdata,  w_resp_rdata_nxt;
    logic              r_resp_error,  w_resp_error_nxt;
    logic [ADDR_W-1:0] r_cache_addr,  w_cache_addr_nxt;
    logic [DATA_W-1:0] r_cache_wdata, w_cache_wdata_nxt;
    logic              r_cache_write, w_cache_write_nxt;
    logic              r_cache_read,  w_cache_read_nxt;

    logic              w_accept;
    logic              w_req_err;
    logic              w_last;
    logic              w_resp_done;

    assign w_accept    = req_valid && r_req_ready;
    assign w_req_err   = lsu_addr_err(64'(req_addr), ADDR_LIMIT);
    assign w_last      = (r_cnt == '0);
    assign w_resp_done = r_resp_valid && resp_ready;

    // State register; every output is registered alongside the FSM state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= '0;
            r_resp_error  <= 1'b0;
            r_cache_addr  <= '0;
            r_cache_wdata <= '0;
            r_cache_write <= 1'b0;
            r_cache_read  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_resp_valid  <= w_resp_valid_nxt;
            r_resp_rdata  <= w_resp_rdata_nxt;
            r_resp_error  <= w_resp_error_nxt;
            r_cache_addr  <= w_cache_addr_nxt;
            r_cache_wdata <= w_cache_wdata_nxt;
            r_cache_write <= w_cache_write_nxt;
            r_cache_read  <= w_cache_read_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = w_req_err ? RESP : ACCESS;
            ACCESS:  if (w_last)      w_state_nxt = RESP;
            RESP:    if (w_resp_done) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and the latency counter.
    always_comb begin
        w_cnt_nxt         = r_cnt;
        w_req_ready_nxt   = r_req_ready;
        w_resp_valid_nxt  = r_resp_valid;
        w_resp_rdata_nxt  = r_resp_rdata;
        w_resp_error_nxt  = r_resp_error;
        w_cache_addr_nxt  = r_cache_addr;
        w_cache_wdata_nxt = r_cache_wdata;
        w_cache_write_nxt = r_cache_write;
        w_cache_read_nxt  = r_cache_read;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_req_ready_nxt = 1'b0;
                    if (w_req_err) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_error_nxt = 1'b1;
                        w_resp_rdata_nxt = '0;
                    end else begin
                        w_cache_addr_nxt  = req_addr;
                        w_cache_wdata_nxt = req_wdata;
                        w_cache_write_nxt = req_write;
                        w_cache_read_nxt  = !req_write;
                        w_cnt_nxt         = CNT_LOAD;
                    end
                end
            end
            ACCESS: begin
                if (w_last) begin
                    if (r_cache_read) w_resp_rdata_nxt = cache_rdata;
                    w_cache_write_nxt = 1'b0;
                    w_cache_read_nxt  = 1'b0;
                    w_resp_valid_nxt  = 1'b1;
                    w_resp_error_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP: begin
                if (w_resp_done) begin
                    w_resp_valid_nxt = 1'b0;
                    w_resp_rdata_nxt = '0;
                    w_resp_error_nxt = 1'b0;
                    w_req_ready_nxt  = 1'b1;
                end
            end
            default: begin
                w_cache_write_nxt = 1'b0;
                w_cache_read_nxt  = 1'b0;
                w_req_ready_nxt   = 1'b1;
            end
        endcase
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_error  = r_resp_error;
    assign cache_addr  = r_cache_addr;
    assign cache_wdata = r_cache_wdata;
    assign cache_write = r_cache_write;
    assign cache_read  = r_cache_read;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data cache interface: accepts one word load/store request from the core and drives the cache strobes and data.
- Holds the strobes for a fixed access latency, then returns load data or a write acknowledgement over a response handshake.
- Sits between the decode/ALU stage (address = ALU result, store data = second register read) and the data cache. Turns the current combinational memory access into a multi-cycle, handshaked transaction.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data word width in bits.
- MEM_WORDS, 64, number of cache words. Legal byte addresses are 0 .. MEM_WORDS*4-1.
- ACCESS_LAT, 2, number of cycles the cache strobe is held per access. Must be at least 1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store (STUR), 0 = load (LDUR).
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  core consumes the response.
- resp_rdata  out  DATA_W  load data; 0 for stores and errors.
- resp_error  out  1  misaligned or out-of-range request.
- cache_addr  out  ADDR_W  address to the cache.
- cache_wdata  out  DATA_W  write data to the cache.
- cache_write  out  1  cache write strobe.
- cache_read  out  1  cache read strobe.
- cache_rdata  in  DATA_W  read data from the cache.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state goes to IDLE and the latency counter clears.
  - req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - cache_addr=0, cache_wdata=0, cache_write=0, cache_read=0.
  - An access interrupted by reset is abandoned; no response is produced for it.
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - req_ready=1.
  - Request is accepted on req_valid && req_ready at edge T.
  - Address, write flag and store data are latched at acceptance; the core may change its inputs afterwards.
  - Error check at acceptance: req_addr[1:0]!=0, or req_addr >= MEM_WORDS*4.
  - Error path: go to RESP with resp_error=1 and resp_rdata=0. No cache strobe is ever asserted. resp_valid=1 in cycle T+1.
  - Legal path: go to ACCESS. cache_addr and cache_wdata are driven from the latched values. cache_write=req_write and cache_read=!req_write, asserted for cycles T+1 .. T+ACCESS_LAT. Counter loads ACCESS_LAT-1.
- ACCESS:
  - req_ready=0.
  - Counter decrements each cycle.
  - On the cycle where the counter is 0:
    - for loads, resp_rdata captures cache_rdata.
    - both strobes drop.
    - go to RESP.
  - resp_valid=1 from cycle T+ACCESS_LAT+1.
  - Exactly one of cache_read and cache_write is high in ACCESS, never both.
- RESP:
  - req_ready=0.
  - resp_valid, resp_rdata and resp_error are held stable until resp_ready=1.
  - On resp_valid && resp_ready: go to IDLE, resp_valid=0, and resp_rdata/resp_error clear to 0.
  - A req_valid asserted during RESP is not accepted. It is accepted at the earliest one cycle after the response handshake.
- Throughput: at most one request in flight.
- Minimum issue interval: ACCESS_LAT+2 cycles with resp_ready held at 1.
- Store response: resp_rdata=0, resp_error=0.
- cache_addr and cache_wdata hold their last values in IDLE and RESP. Only the strobes carry meaning.
- Address comparison is unsigned, full ADDR_W width. There is no wrap-around: address 0xFFFFFFFC is out of range.

Decomposition:
- Package lsu_pkg holds:
  - state enum encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - WORD_BYTES=4.
  - error-check helper (alignment plus range).
- No sub-module; the latency counter and FSM live in a single module.

Test Plan (ACCESS_LAT=2, MEM_WORDS=64):
- Store then load: store 0xDEADBEEF to address 0x10, then load 0x10.
  - Store: cache_write high exactly 2 cycles with cache_addr=0x10; resp_valid at T+3 with rdata=0, error=0.
  - Load: cache_read high 2 cycles; resp_rdata=0xDEADBEEF.
- Misaligned load at address 0x13:
  - No strobe asserted.
  - resp_valid at T+1 with resp_error=1, resp_rdata=0.
- Out-of-range store at address 0x100:
  - cache_write never asserted.
  - resp_error=1; a subsequent load of 0x0 returns the original contents.
- Backpressure: resp_ready held low for 5 cycles after a load of 0x10.
  - resp_valid and resp_rdata stay stable throughout.
  - req_ready=0 and a concurrent req_valid is not accepted.
  - The request is accepted one cycle after the handshake.
- Reset mid-access: assert reset during the first ACCESS cycle of a store.
  - Strobes drop immediately; all outputs return to reset values; no resp_valid.
  - After reset release, a load of the same address returns the pre-store value.
- Back-to-back loads of 0x0, 0x4 and 0x8 with resp_ready=1:
  - Accepts are spaced exactly 4 cycles apart.
  - Data matches the preloaded cache contents.
